// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: operation, read-stall and HI/LO write-back signals of the multiply/divide unit
// master: issues operations (i_op_*), flushes (i_flush), reports MFHI/MFLO reads (i_hl_rd_req)
// slave:  returns o_op_ready/o_busy/o_stall, the HI/LO write port (o_wr_*) and o_div_by_zero
interface mips_muldiv_if;
  logic        i_op_valid;
  logic [2:0]  i_op_code;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_flush;
  logic        i_hl_rd_req;
  logic        o_op_ready;
  logic        o_busy;
  logic        o_stall;
  logic [1:0]  o_wr_en;
  logic [31:0] o_wr_hdata;
  logic [31:0] o_wr_ldata;
  logic        o_div_by_zero;
  modport master (
    output i_op_valid, i_op_code, i_op_a, i_op_b, i_flush, i_hl_rd_req,
    input  o_op_ready, o_busy, o_stall, o_wr_en, o_wr_hdata, o_wr_ldata, o_div_by_zero
  );
  modport slave (
    input  i_op_valid, i_op_code, i_op_a, i_op_b, i_flush, i_hl_rd_req,
    output o_op_ready, o_busy, o_stall, o_wr_en, o_wr_hdata, o_wr_ldata, o_div_by_zero
  );
endinterface

// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit, 32 radix-2 steps per mul/div
// clk, rst: clock and synchronous active-high reset
// bus (mips_muldiv_if.slave): operation request in, ready/busy/stall and HI/LO write port out
// MIPS_MULDIV_DIV_EN: when defined, DIV/DIVU are built in; otherwise they are treated as reserved
module mips_muldiv_ctrl (
  input  logic         clk,
  input  logic         rst,
  mips_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_negq;
  logic        w_acc, w_code_ok, w_sgn, w_a_neg, w_b_neg;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_sum;
  logic [63:0] w_prod;
`ifdef MIPS_MULDIV_DIV_EN
  logic        r_negr;
  logic [32:0] w_shl;
  logic        w_ge;
  assign w_code_ok = bus.i_op_code[2:1] != 2'b11;
  // restoring step: shift the next dividend bit into the partial remainder
  assign w_shl = {r_hi, r_lo[31]};
  assign w_ge  = w_shl >= {1'b0, r_b};
  always_ff @(posedge clk)
    if (rst) r_negr <= 1'b0;
    else if (w_acc) r_negr <= w_a_neg;
`else
  assign w_code_ok = ~bus.i_op_code[1];
`endif
  assign w_acc   = r_state == S_IDLE && bus.i_op_valid && !bus.i_flush && w_code_ok;
  assign w_sgn   = ~bus.i_op_code[2] & ~bus.i_op_code[0];
  assign w_a_neg = w_sgn & bus.i_op_a[31];
  assign w_b_neg = w_sgn & bus.i_op_b[31];
  assign w_abs_a = w_a_neg ? -bus.i_op_a : bus.i_op_a;
  assign w_abs_b = w_b_neg ? -bus.i_op_b : bus.i_op_b;
  // shift-add step: r_lo holds the remaining multiplier bits, the carry lands in w_sum[32]
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_prod  = r_negq ? -{r_hi, r_lo} : {r_hi, r_lo};
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_acc ? (bus.i_op_code[2] ? S_WRITE : S_RUN) : S_IDLE;
      S_RUN:   w_next = bus.i_flush ? S_IDLE : (r_cnt == 5'd31 ? S_WRITE : S_RUN);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_negq <= 1'b0;
    end else if (w_acc) begin
      r_cnt  <= '0;
      r_op   <= bus.i_op_code;
      r_a    <= bus.i_op_a;
      r_b    <= w_abs_b;
      r_hi   <= '0;
      r_lo   <= w_abs_a;
      r_negq <= w_a_neg ^ w_b_neg;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 5'd1;
`ifdef MIPS_MULDIV_DIV_EN
      if (r_op[2:1] == 2'b01)
        {r_hi, r_lo} <= {w_ge ? w_shl[31:0] - r_b : w_shl[31:0], r_lo[30:0], w_ge};
      else
`endif
        {r_hi, r_lo} <= {w_sum, r_lo[31:1]};
    end
  always_comb begin
    bus.o_wr_en       = 2'b00;
    bus.o_wr_hdata    = '0;
    bus.o_wr_ldata    = '0;
    bus.o_div_by_zero = 1'b0;
    if (r_state == S_WRITE) begin
      if (r_op == 3'b100) begin
        bus.o_wr_en    = 2'b10;
        bus.o_wr_hdata = r_a;
      end else if (r_op == 3'b101) begin
        bus.o_wr_en    = 2'b01;
        bus.o_wr_ldata = r_a;
      end
`ifdef MIPS_MULDIV_DIV_EN
      else if (r_op[2:1] == 2'b01) begin
        bus.o_wr_en       = 2'b11;
        bus.o_div_by_zero = r_b == '0;
        bus.o_wr_hdata    = r_b == '0 ? r_a : (r_negr ? -r_hi : r_hi);
        bus.o_wr_ldata    = r_b == '0 ? '1 : (r_negq ? -r_lo : r_lo);
      end
`endif
      else begin
        bus.o_wr_en    = 2'b11;
        bus.o_wr_hdata = w_prod[63:32];
        bus.o_wr_ldata = w_prod[31:0];
      end
    end
  end
  assign bus.o_op_ready = r_state == S_IDLE;
  assign bus.o_busy     = r_state != S_IDLE;
  assign bus.o_stall    = bus.i_hl_rd_req && r_state != S_IDLE;
endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb_mips_muldiv_ctrl: random and directed stimulus checked every cycle against a cycle-count reference model
module tb_mips_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mips_muldiv_if bus();
  mips_muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int t = 0;
  bit armed = 1'b0;
  bit mt = 1'b0;
  logic [1:0]  m_en;
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;
  int cyc = 0, acc_cyc = -1, wr_rel = -1, rdy_rel = -1, stall_cnt = 0, dbz_cnt = 0;
  logic [1:0]  cap_en;
  logic [31:0] cap_hi, cap_lo;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic bit code_ok(input logic [2:0] c);
`ifdef MIPS_MULDIV_DIV_EN
    return c <= 3'd5;
`else
    return c == 3'd0 || c == 3'd1 || c == 3'd4 || c == 3'd5;
`endif
  endfunction
  task automatic model_result(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    m_dbz = 1'b0;
    m_en  = 2'b11;
    case (c)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      3'd1: begin p = 64'(a) * 64'(b); {m_hi, m_lo} = p; end
      3'd2: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; m_dbz = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_lo = 32'h80000000; m_hi = 0; end
        else begin m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); end
      end
      3'd3: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; m_dbz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: begin m_en = 2'b10; m_hi = a; m_lo = 0; end
      default: begin m_en = 2'b01; m_hi = 0; m_lo = a; end
    endcase
  endtask
  always @(negedge clk) begin
    bit wr;
    #1;
    cyc++;
    wr = t != 0 && (mt ? t == 1 : t == 33);
    if (armed) begin
      chk("op_ready", bus.o_op_ready, t == 0);
      chk("busy", bus.o_busy, t != 0);
      chk("stall", bus.o_stall, t != 0 && bus.i_hl_rd_req);
      chk("wr_en", bus.o_wr_en, wr ? m_en : 2'b00);
      chk("wr_hdata", bus.o_wr_hdata, wr ? m_hi : 32'h0);
      chk("wr_ldata", bus.o_wr_ldata, wr ? m_lo : 32'h0);
      chk("div_by_zero", bus.o_div_by_zero, wr && m_dbz);
      if (acc_cyc >= 0 && cyc > acc_cyc) begin
        if (bus.o_wr_en !== 2'b00 && wr_rel < 0) begin
          wr_rel = cyc - acc_cyc;
          cap_en = bus.o_wr_en;
          cap_hi = bus.o_wr_hdata;
          cap_lo = bus.o_wr_ldata;
        end
        if (rdy_rel < 0 && bus.o_op_ready === 1'b1) rdy_rel = cyc - acc_cyc;
        if (t != 0 && bus.o_stall === 1'b1) stall_cnt++;
        if (bus.o_div_by_zero === 1'b1) dbz_cnt++;
      end
    end
    if (rst) begin
      t = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (t == 0) begin
        if (bus.i_op_valid && !bus.i_flush && code_ok(bus.i_op_code)) begin
          t = 1;
          mt = bus.i_op_code[2];
          model_result(bus.i_op_code, bus.i_op_a, bus.i_op_b);
          acc_cyc = cyc;
          wr_rel = -1;
          rdy_rel = -1;
          stall_cnt = 0;
          dbz_cnt = 0;
        end
      end else if (wr) t = 0;
      else if (bus.i_flush) t = 0;
      else t++;
    end
  end
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int flush_at, input logic hl);
    @(negedge clk);
    bus.i_op_valid = 1'b1;
    bus.i_op_code = c;
    bus.i_op_a = a;
    bus.i_op_b = b;
    bus.i_hl_rd_req = hl;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    bus.i_op_a = $urandom;
    bus.i_op_b = $urandom;
    for (int i = 1; i < 40; i++) begin
      if (i == flush_at) bus.i_flush = 1'b1;
      @(negedge clk);
      bus.i_flush = 1'b0;
    end
    bus.i_hl_rd_req = 1'b0;
  endtask
  initial begin
    bus.i_op_valid = 1'b0;
    bus.i_op_code = 3'd0;
    bus.i_op_a = 32'h0;
    bus.i_op_b = 32'h0;
    bus.i_flush = 1'b0;
    bus.i_hl_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_op_ready", bus.o_op_ready, 1'b1);
    chk("reset_busy", bus.o_busy, 1'b0);
    chk("reset_wr_en", bus.o_wr_en, 2'b00);
    chk("reset_div_by_zero", bus.o_div_by_zero, 1'b0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1);
    chk("multu_wr_cycle", wr_rel, 33);
    chk("multu_wr_en", cap_en, 2'b11);
    chk("multu_hi", cap_hi, 32'hFFFFFFFE);
    chk("multu_lo", cap_lo, 32'h00000001);
    chk("multu_ready_cycle", rdy_rel, 34);
    chk("multu_stall_cycles", stall_cnt, 33);
    do_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, 1'b0);
    chk("mult_hi", cap_hi, 32'hFFFFFFFF);
    chk("mult_lo", cap_lo, 32'hFFFFFFEB);
`ifdef MIPS_MULDIV_DIV_EN
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    chk("div_lo", cap_lo, 32'hFFFFFFFD);
    chk("div_hi", cap_hi, 32'hFFFFFFFF);
    do_op(3'd3, 32'd100, 32'd0, 0, 1'b1);
    chk("divu0_wr_cycle", wr_rel, 33);
    chk("divu0_hi", cap_hi, 32'd100);
    chk("divu0_lo", cap_lo, 32'hFFFFFFFF);
    chk("divu0_dbz_pulses", dbz_cnt, 1);
    chk("divu0_stall_cycles", stall_cnt, 33);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    chk("div_ovf_lo", cap_lo, 32'h80000000);
    chk("div_ovf_hi", cap_hi, 32'h0);
`else
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
`endif
    do_op(3'd0, 32'd5, 32'd9, 10, 1'b0);
    chk("flush_no_write", wr_rel, -1);
    chk("flush_ready_cycle", rdy_rel, 11);
    do_op(3'd1, 32'd6, 32'd7, 33, 1'b0);
    chk("flush_in_write_cycle", wr_rel, 33);
    chk("flush_in_write_lo", cap_lo, 32'd42);
    do_op(3'd5, 32'h1234, 32'h0, 0, 1'b0);
    chk("mtlo_wr_cycle", wr_rel, 1);
    chk("mtlo_wr_en", cap_en, 2'b01);
    chk("mtlo_ldata", cap_lo, 32'h1234);
    chk("mtlo_ready_cycle", rdy_rel, 2);
    do_op(3'd4, 32'hCAFEF00D, 32'h0, 0, 1'b0);
    chk("mthi_wr_en", cap_en, 2'b10);
    chk("mthi_hdata", cap_hi, 32'hCAFEF00D);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      bus.i_op_valid = $urandom_range(0, 3) == 0;
      bus.i_op_code = 3'($urandom);
      bus.i_op_a = pick();
      bus.i_op_b = pick();
      bus.i_flush = $urandom_range(0, 99) == 0;
      bus.i_hl_rd_req = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_ctrl.md
MIPS_MULDIV_CTRL -- requirements
Module: mips_muldiv_ctrl

Interface
REQ-001 SHALL have clk, input, 1: clock, all state updates on rising edge.
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have op_valid, input, 1: operation request.
REQ-004 SHALL have op_code, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-005 SHALL have op_a, input, 32: rs operand (dividend, multiplicand, MTHI/MTLO data).
REQ-006 SHALL have op_b, input, 32: rt operand (divisor, multiplier).
REQ-007 SHALL have flush, input, 1: abort in-flight operation.
REQ-008 SHALL have hl_rd_req, input, 1: MFHI/MFLO present in the read stage.
REQ-009 SHALL have op_ready, output, 1: high only in IDLE.
REQ-010 SHALL have busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have stall, output, 1: equal to hl_rd_req AND busy.
REQ-012 SHALL have wr_en, output, 2: HI/LO write enables, bit1 HI, bit0 LO.
REQ-013 SHALL have wr_hdata and wr_ldata, outputs, 32 each: HI/LO write data.
REQ-014 SHALL have div_by_zero, output, 1: one-cycle pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, WRITE; 5-bit iteration counter.
REQ-016 SHALL accept an operation in cycle 0 when op_valid, op_ready high, flush low, op_code not reserved; reserved codes ignored, state unchanged.
REQ-017 SHALL, for MULT/MULTU/DIV/DIVU, spend cycles 1..32 in RUN (one radix-2 iteration per cycle), cycle 33 in WRITE, cycle 34 in IDLE.
REQ-018 SHALL, for MTHI/MTLO, go directly to WRITE in cycle 1, IDLE in cycle 2.
REQ-019 SHALL drive wr_en only in WRITE: 11 for mul/div, 10 for MTHI (wr_hdata=op_a), 01 for MTLO (wr_ldata=op_a); 00 elsewhere.
REQ-020 SHALL hold wr_hdata/wr_ldata at 0 outside WRITE.
REQ-021 SHALL compute MULTU as unsigned 32x32->64 shift-add; HI=upper, LO=lower.
REQ-022 SHALL compute MULT on absolute values, then negate the 64-bit product when operand signs differ.
REQ-023 SHALL compute DIVU by restoring division; LO=quotient, HI=remainder.
REQ-024 SHALL compute DIV on absolute values; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a); 0x80000000/-1 gives LO=0x80000000, HI=0.
REQ-025 SHALL, on divisor 0 (DIV or DIVU), keep 33-cycle latency, write HI=op_a, LO=0xFFFFFFFF, pulse div_by_zero in WRITE.
REQ-026 SHALL latch operands at acceptance; op_a/op_b changes afterwards have no effect.
REQ-027 SHALL, on flush in RUN, enter IDLE next edge with no write; flush in WRITE is ignored, write completes.
REQ-028 SHALL assert stall during WRITE too; HI/LO register holds the result by the following IDLE cycle.

Reset
REQ-029 SHALL, on rst, enter IDLE, clear counter and operand registers; outputs: op_ready=1, busy=0, stall=0, wr_en=00, data 0, div_by_zero=0.
REQ-030 SHALL, on rst mid-operation (RUN or WRITE), abandon with no write in following cycles; rst takes priority over flush and op_valid.

Configuration
REQ-031 SHALL, with MIPS_MULDIV_DIV_EN defined, include the divider per REQ-023..025.
REQ-032 SHALL, without MIPS_MULDIV_DIV_EN, omit divider logic, treat DIV/DIVU as reserved (ignored, no write), tie div_by_zero to 0.

Verification
REQ-033 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> cycle 33 wr_en=11, HI=0xFFFFFFFE, LO=0x00000001; op_ready cycle 34.
REQ-034 SHALL test MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 SHALL test DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> HI=100, LO=0xFFFFFFFF, div_by_zero pulse.
REQ-036 SHALL test flush in cycle 10 of MULT -> no wr_en ever, op_ready cycle 11.
REQ-037 SHALL test MTLO 0x1234 -> cycle 1 wr_en=01, wr_ldata=0x1234; hl_rd_req during DIVU -> stall high cycles 1..33, low cycle 34.
